// File: rtl/if_pc_sequencer_if.sv
// IF-stage bus between the fetch PC sequencer and the surrounding datapath:
// PC-increment / imem / hazard / redirect inputs and the IF/ID register outputs.
interface if_pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] inc_pc;
  logic [31:0]     instr_in;
  logic            stall;
  logic            flush;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;

  logic [XLEN-1:0] PC_out;
  logic [XLEN-1:0] IF_ID_pc;
  logic [XLEN-1:0] IF_ID_inc_pc;
  logic [31:0]     IF_ID_instr;
  logic            IF_ID_valid;
  logic            misalign_err;

  // master = the sequencer, slave = IF/ID datapath and hazard logic around it
  modport master (
    input  inc_pc, instr_in, stall, flush, branch_taken, branch_target,
    output PC_out, IF_ID_pc, IF_ID_inc_pc, IF_ID_instr, IF_ID_valid, misalign_err
  );

  modport slave (
    output inc_pc, instr_in, stall, flush, branch_taken, branch_target,
    input  PC_out, IF_ID_pc, IF_ID_inc_pc, IF_ID_instr, IF_ID_valid, misalign_err
  );
endinterface

// File: rtl/if_pc_sequencer.sv
// Fetch PC register and IF/ID pipeline register with redirect > stall > flush priority.
// Every output comes straight from a flop; no input reaches an output combinationally.
module if_pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]     NOP_INSTR    = 32'h0000_0013
) (
  input logic               clk,
  input logic               rst,
  if_pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    CTL_NORMAL,
    CTL_FLUSH,
    CTL_STALL,
    CTL_REDIRECT
  } ctl_e;

  ctl_e            ctl;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_inc_q, id_inc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            id_valid_q, id_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] redirect_pc;
  logic            target_misaligned;

  assign redirect_pc       = {bus.branch_target[XLEN-1:2], 2'b00};
  assign target_misaligned = (bus.branch_target[1:0] != 2'b00);

  always_comb begin
    ctl = CTL_NORMAL;
    if (bus.branch_taken) begin
      ctl = CTL_REDIRECT;
    end else if (bus.stall) begin
      ctl = CTL_STALL;
    end else if (bus.flush) begin
      ctl = CTL_FLUSH;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inc_d   = id_inc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    misalign_d = 1'b0;
    unique case (ctl)
      CTL_NORMAL: begin
        pc_d       = bus.inc_pc;
        id_pc_d    = pc_q;
        id_inc_d   = bus.inc_pc;
        id_instr_d = bus.instr_in;
        id_valid_d = 1'b1;
      end
      // PC fields still load on a squash so a debugger can see what was dropped
      CTL_FLUSH: begin
        pc_d       = bus.inc_pc;
        id_pc_d    = pc_q;
        id_inc_d   = bus.inc_pc;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
      CTL_STALL: begin
        pc_d       = pc_q;
      end
      CTL_REDIRECT: begin
        pc_d       = redirect_pc;
        id_pc_d    = pc_q;
        id_inc_d   = bus.inc_pc;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
        misalign_d = target_misaligned;
      end
      default: begin
        pc_d       = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      id_pc_q    <= '0;
      id_inc_q   <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inc_q   <= id_inc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.PC_out       = pc_q;
  assign bus.IF_ID_pc     = id_pc_q;
  assign bus.IF_ID_inc_pc = id_inc_q;
  assign bus.IF_ID_instr  = id_instr_q;
  assign bus.IF_ID_valid  = id_valid_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Bench for if_pc_sequencer: directed scenarios plus randomized control traffic,
// all checked against a cycle-level reference model of the fetch PC and IF/ID entry.
module tb_if_pc_sequencer;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_pc_sequencer_if #(.XLEN(32)) bus ();

  if_pc_sequencer #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference state: what the fetch PC and IF/ID entry must be after the last edge
  logic [31:0] m_pc, m_id_pc, m_id_inc, m_id_instr;
  logic        m_valid, m_mis;
  logic        m_pcs_defined;  // IF_ID_pc/inc_pc are unspecified after a redirect

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("PC_out", bus.PC_out, m_pc);
    chk("IF_ID_instr", bus.IF_ID_instr, m_id_instr);
    chk("IF_ID_valid", 32'(bus.IF_ID_valid), 32'(m_valid));
    chk("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
    if (m_pcs_defined) begin
      chk("IF_ID_pc", bus.IF_ID_pc, m_id_pc);
      chk("IF_ID_inc_pc", bus.IF_ID_inc_pc, m_id_inc);
    end
  endtask

  // Apply one cycle of inputs, advance the model, cross the edge, then compare.
  task automatic step(input logic r, input logic s, input logic f, input logic b,
                      input logic [31:0] tgt, input logic [31:0] inc, input logic [31:0] ins);
    rst               = r;
    bus.stall         = s;
    bus.flush         = f;
    bus.branch_taken  = b;
    bus.branch_target = tgt;
    bus.inc_pc        = inc;
    bus.instr_in      = ins;
    if (r) begin
      m_pc = 32'h0; m_id_pc = 32'h0; m_id_inc = 32'h0; m_id_instr = NOP;
      m_valid = 1'b0; m_mis = 1'b0; m_pcs_defined = 1'b1;
    end else if (b) begin
      m_pc       = tgt & 32'hFFFF_FFFC;
      m_id_instr = NOP;
      m_valid    = 1'b0;
      m_mis      = (tgt % 4) != 0;
      m_pcs_defined = 1'b0;
    end else if (s) begin
      m_mis = 1'b0;
    end else begin
      m_id_pc    = m_pc;
      m_id_inc   = inc;
      m_id_instr = f ? NOP : ins;
      m_valid    = !f;
      m_pc       = inc;
      m_mis      = 1'b0;
      m_pcs_defined = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic norm();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, m_pc + 32'd4, $urandom);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, $urandom);
  endtask

  initial begin
    m_pcs_defined = 1'b0;
    do_reset();
    chk("reset_pc", bus.PC_out, 32'h0);
    chk("reset_valid", 32'(bus.IF_ID_valid), 32'd0);
    chk("reset_instr", bus.IF_ID_instr, NOP);

    // free-run from reset
    norm();
    chk("t1_pc_e1", bus.PC_out, 32'h4);
    chk("t1_idpc_e1", bus.IF_ID_pc, 32'h0);
    chk("t1_valid_e1", 32'(bus.IF_ID_valid), 32'd1);
    norm();
    norm();
    chk("t1_pc_e3", bus.PC_out, 32'hC);
    chk("t1_idpc_e3", bus.IF_ID_pc, 32'h8);

    // stall two edges at PC 8
    do_reset();
    norm();
    norm();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, m_pc + 32'd4, $urandom);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, m_pc + 32'd4, $urandom);
    chk("t2_pc_hold", bus.PC_out, 32'h8);
    chk("t2_idpc_hold", bus.IF_ID_pc, 32'h4);
    norm();
    chk("t2_pc_resume", bus.PC_out, 32'hC);

    // redirect overrides stall
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, m_pc + 32'd4, $urandom);
    chk("t3_pc", bus.PC_out, 32'h40);
    chk("t3_valid", 32'(bus.IF_ID_valid), 32'd0);
    chk("t3_instr", bus.IF_ID_instr, 32'h13);
    norm();
    chk("t3_idpc", bus.IF_ID_pc, 32'h40);
    chk("t3_valid_next", 32'(bus.IF_ID_valid), 32'd1);

    // misaligned redirect pulses misalign_err once
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h42, m_pc + 32'd4, $urandom);
    chk("t4_pc", bus.PC_out, 32'h40);
    chk("t4_mis", 32'(bus.misalign_err), 32'd1);
    norm();
    chk("t4_mis_clear", 32'(bus.misalign_err), 32'd0);

    // flush at PC 16, then wrap-around
    do_reset();
    repeat (4) norm();
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, m_pc + 32'd4, 32'hDEAD_BEEF);
    chk("t5_valid", 32'(bus.IF_ID_valid), 32'd0);
    chk("t5_instr", bus.IF_ID_instr, 32'h13);
    chk("t5_pc", bus.PC_out, 32'h14);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, m_pc + 32'd4, $urandom);
    norm();
    chk("t5_wrap_pc", bus.PC_out, 32'h0);
    chk("t5_wrap_idpc", bus.IF_ID_pc, 32'hFFFF_FFFC);
    chk("t5_wrap_inc", bus.IF_ID_inc_pc, 32'h0);

    // reset during stall (misaligned redirect also requested, reset must win)
    norm();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h42, m_pc + 32'd4, $urandom);
    chk("t6_pc", bus.PC_out, 32'h0);
    chk("t6_valid", 32'(bus.IF_ID_valid), 32'd0);
    chk("t6_mis", 32'(bus.misalign_err), 32'd0);
    norm();
    chk("t6_first_idpc", bus.IF_ID_pc, 32'h0);
    chk("t6_first_valid", 32'(bus.IF_ID_valid), 32'd1);

    // randomized control traffic
    for (int i = 0; i < 600; i++) begin
      logic        r, s, f, b;
      logic [31:0] inc;
      r   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 4) == 0);
      f   = ($urandom_range(0, 5) == 0);
      b   = ($urandom_range(0, 7) == 0);
      inc = ($urandom_range(0, 9) == 0) ? $urandom : m_pc + 32'd4;
      step(r, s, f, b, $urandom, inc, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
